regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised integer register file with a per-register pending-write scoreboard. Intended as the next-generation register file for the pipelined core.
- Two combinational read ports, one synchronous write port, optional hardwired-zero register 0, optional write-to-read bypass.
- Async reset clears all registers and all pending bits.
- Decode uses busy flags to detect RAW hazards; writeback clears them.

Parameters:
XLEN, 32, data width of each register
AW, 5, address width; register count NREGS = 2**AW
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never becomes pending
BYPASS, 1, 1 = same-cycle write data forwarded to read ports and clears busy flags combinationally

Ports:
clk  in  1  clock, rising-edge
rst  in  1  reset, asynchronous, active-high
we  in  1  write enable (writeback stage)
wa  in  AW  write address
wd  in  XLEN  write data
ra1  in  AW  read address, port 1
ra2  in  AW  read address, port 2
rd1  out  XLEN  read data, port 1 (combinational)
rd2  out  XLEN  read data, port 2 (combinational)
iss_valid  in  1  issue request: mark iss_rd pending
iss_rd  in  AW  destination register of issuing instruction
iss_ready  out  1  issue accepted this cycle
busy1  out  1  ra1 has an outstanding write
busy2  out  1  ra2 has an outstanding write
pend_cnt  out  AW+1  number of pending registers

Behaviour:
- Storage: regs[NREGS] of XLEN bits and pend[NREGS] of 1 bit. Both cleared to 0 asynchronously when rst=1. While rst is high, all state holds 0 and writes/issues are ignored.
- Reset output values: rd1 = rd2 = 0, busy1 = busy2 = 0, pend_cnt = 0, iss_ready = 1.
- Write:
  - At posedge clk, if we=1 and not (ZERO_REG and wa==0): regs[wa] <= wd and pend[wa] <= 0, unless an issue to the same register is accepted that cycle (see simultaneous events).
  - A write to a non-pending register is legal: data updates, pend stays 0.
- Read, port n, combinational:
  - If ZERO_REG and ran==0: rdn = 0.
  - Else if BYPASS and we and wa==ran: rdn = wd.
  - Else: rdn = regs[ran].
- Busy, port n:
  - busyn = pend[ran].
  - When BYPASS=1: busyn = 0 if we and wa==ran (writeback resolves the hazard this cycle).
  - busyn = 0 when ZERO_REG and ran==0.
- Issue:
  - iss_ready = 1 unless pend[iss_rd]=1 and not (BYPASS and we and wa==iss_rd). This blocks WAW on an already-pending destination.
  - iss_ready is independent of iss_valid. It is always 1 for iss_rd==0 when ZERO_REG.
  - Accepted issue = iss_valid & iss_ready. It sets pend[iss_rd] <= 1 at posedge, except for iss_rd==0 with ZERO_REG (accepted, no effect).
- Simultaneous events:
  - we and accepted issue to the same register in one cycle: regs updated with wd, pend ends at 1 (new producer wins).
  - we and issue to different registers: both take effect.
  - With BYPASS=0, the same-register case is not ready if the register was pending (issue stalls one cycle).
- pend_cnt:
  - Registered population count of pend, updated each posedge as +1 / -1 / 0 / net.
  - Range 0..NREGS-1 when ZERO_REG, otherwise 0..NREGS.
  - Must always equal popcount(pend).
- Latency: write visible on read ports the next cycle; same cycle with BYPASS=1. Pending set visible on busy the cycle after the issue.

Test Plan:
- Reset mid-operation: pend[3] = 1 and regs[3] = 0x55, assert rst asynchronously between edges → rd1 = 0 and busy1 = 0 immediately; pend_cnt = 0; iss_ready = 1.
- Write x0: we=1, wa=0, wd=0xDEADBEEF, then ra1=0 → rd1 = 0. iss_valid=1, iss_rd=0 → iss_ready = 1, pend_cnt stays 0 (ZERO_REG=1).
- Bypass: BYPASS=1, pend[5] = 1, we=1, wa=5, wd=0x1234, ra1=5, ra2=5 in the same cycle → rd1 = rd2 = 0x1234 and busy1 = busy2 = 0 that cycle. Next cycle: pend[5] = 0, pend_cnt decremented by 1.
- WAW stall: issue rd=7 (accepted), then issue rd=7 again → iss_ready = 0, pend_cnt stays 1. Write wa=7 with BYPASS=1 → iss_ready = 1 same cycle; accepted issue leaves pend[7] = 1 and pend_cnt = 1.
- Fill: issue rd=1..31 on consecutive cycles, no writes → pend_cnt = 31 and busy set for all nonzero addresses. Then write rd=31..1 → pend_cnt reaches 0 and data reads back correctly.
- Parameter sweep: XLEN=64, AW=4, ZERO_REG=0, BYPASS=0. Write reg 0 = 0xFFFF_0000_FFFF_0000 → reads back that value next cycle, not the same cycle. Issue all 16 registers → pend_cnt = 16.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised integer register file with a per-register
// pending-write scoreboard. Two combinational read ports, one synchronous
// write port, optional hardwired-zero x0 and optional write-to-read bypass.
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  output logic            iss_ready,
  output logic            busy1,
  output logic            busy2,
  output logic [AW:0]     pend_cnt
);

  localparam int NREGS = 2**AW;

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_pend;
  logic [AW:0]      r_pend_cnt;

  logic w_wr_en;       // write actually lands in the array
  logic w_hit1;        // writeback forwards to read port 1
  logic w_hit2;        // writeback forwards to read port 2
  logic w_hit_iss;     // writeback resolves the issue destination this cycle
  logic w_iss_en;      // accepted issue that really marks a register pending
  logic w_cnt_inc;
  logic w_cnt_dec;

  // Qualify write, issue and the pending-count delta for this cycle.
  // NOTE: every always_comb output gets a value on every path (here by
  // unconditional assignment), otherwise synthesis infers a latch.
  always_comb begin
    w_wr_en   = we && !(ZERO_REG && (wa == '0));
    w_hit1    = BYPASS && we && (wa == ra1);
    w_hit2    = BYPASS && we && (wa == ra2);
    w_hit_iss = BYPASS && we && (wa == iss_rd);
    iss_ready = !(r_pend[iss_rd] && !w_hit_iss);
    w_iss_en  = iss_valid && iss_ready && !(ZERO_REG && (iss_rd == '0));
    // A register becomes newly pending only if it was clear before; a write
    // clears one only if no same-register issue re-arms it in this cycle.
    w_cnt_inc = w_iss_en && !r_pend[iss_rd];
    w_cnt_dec = w_wr_en && r_pend[wa] && !(w_iss_en && (iss_rd == wa));
  end

  // Combinational read ports with x0 forcing and optional bypass.
  always_comb begin
    rd1   = r_regs[ra1];
    rd2   = r_regs[ra2];
    busy1 = r_pend[ra1] && !w_hit1;
    busy2 = r_pend[ra2] && !w_hit2;
    if (w_hit1) rd1 = wd;
    if (w_hit2) rd2 = wd;
    if (ZERO_REG && (ra1 == '0)) begin
      rd1   = '0;
      busy1 = 1'b0;
    end
    if (ZERO_REG && (ra2 == '0)) begin
      rd2   = '0;
      busy2 = 1'b0;
    end
  end

  // Register array: cleared by reset, written by the writeback stage.
  // NOTE: the storage array is reset on purpose because every register must
  // read back as zero after reset; this keeps it in flops, not a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[wa] <= wd;
    end
  end

  // Pending bits: writeback clears, accepted issue sets; issue wins a tie.
  // NOTE: sequential state uses non-blocking assignments; with two to the
  // same bit in one block the later one wins, which gives issue priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
    end else begin
      if (w_wr_en)  r_pend[wa]     <= 1'b0;
      if (w_iss_en) r_pend[iss_rd] <= 1'b1;
    end
  end

  // Running population count of the pending bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_cnt <= '0;
    end else begin
      case ({w_cnt_inc, w_cnt_dec})
        2'b10:   r_pend_cnt <= r_pend_cnt + (AW+1)'(1);
        2'b01:   r_pend_cnt <= r_pend_cnt - (AW+1)'(1);
        default: r_pend_cnt <= r_pend_cnt;
      endcase
    end
  end

  assign pend_cnt = r_pend_cnt;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: self-checking bench for regfile_sb. Instance u0 uses the
// default configuration, u1 uses XLEN=64, AW=4, ZERO_REG=0, BYPASS=0.
module tb_regfile_sb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance 0 signals (32-bit, 32 regs, zero reg, bypass)
  logic        we0 = 1'b0, iv0 = 1'b0;
  logic [4:0]  wa0 = '0, ra1_0 = '0, ra2_0 = '0, ird0 = '0;
  logic [31:0] wd0 = '0;
  logic [31:0] rd1_0, rd2_0;
  logic        rdy0, b1_0, b2_0;
  logic [5:0]  cnt0;

  // Instance 1 signals (64-bit, 16 regs, no zero reg, no bypass)
  logic        we1 = 1'b0, iv1 = 1'b0;
  logic [3:0]  wa1 = '0, ra1_1 = '0, ra2_1 = '0, ird1 = '0;
  logic [63:0] wd1 = '0;
  logic [63:0] rd1_1, rd2_1;
  logic        rdy1, b1_1, b2_1;
  logic [4:0]  cnt1;

  regfile_sb u0 (
    .clk(clk), .rst(rst), .we(we0), .wa(wa0), .wd(wd0),
    .ra1(ra1_0), .ra2(ra2_0), .rd1(rd1_0), .rd2(rd2_0),
    .iss_valid(iv0), .iss_rd(ird0), .iss_ready(rdy0),
    .busy1(b1_0), .busy2(b2_0), .pend_cnt(cnt0)
  );

  regfile_sb #(.XLEN(64), .AW(4), .ZERO_REG(1'b0), .BYPASS(1'b0)) u1 (
    .clk(clk), .rst(rst), .we(we1), .wa(wa1), .wd(wd1),
    .ra1(ra1_1), .ra2(ra2_1), .rd1(rd1_1), .rd2(rd2_1),
    .iss_valid(iv1), .iss_rd(ird1), .iss_ready(rdy1),
    .busy1(b1_1), .busy2(b2_1), .pend_cnt(cnt1)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (index k selects the instance) -------
  logic [63:0] m_regs [2][32];
  bit          m_pend [2][32];

  function automatic bit zr(int k); return (k == 0); endfunction
  function automatic bit bp(int k); return (k == 0); endfunction

  task automatic m_clear();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 32; i++) begin
        m_regs[k][i] = '0;
        m_pend[k][i] = 1'b0;
      end
  endtask

  function automatic logic [63:0] m_rd(int k, int ra, bit we, int wa, logic [63:0] wd);
    if (zr(k) && ra == 0) return '0;
    if (bp(k) && we && wa == ra) return wd;
    return m_regs[k][ra];
  endfunction

  function automatic bit m_busy(int k, int ra, bit we, int wa);
    if (zr(k) && ra == 0) return 1'b0;
    if (bp(k) && we && wa == ra) return 1'b0;
    return m_pend[k][ra];
  endfunction

  function automatic bit m_ready(int k, int rd, bit we, int wa);
    return !(m_pend[k][rd] && !(bp(k) && we && wa == rd));
  endfunction

  function automatic int m_count(int k);
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_pend[k][i]);
    return n;
  endfunction

  task automatic m_step(int k, bit we, int wa, logic [63:0] wd, bit iv, int ird);
    bit acc;
    acc = iv && m_ready(k, ird, we, wa);
    if (we && !(zr(k) && wa == 0)) begin
      m_regs[k][wa] = wd;
      m_pend[k][wa] = 1'b0;
    end
    if (acc && !(zr(k) && ird == 0)) m_pend[k][ird] = 1'b1;
  endtask

  // Compare every output of both instances against the model.
  task automatic check_model(input string tag);
    check($sformatf("%s u0.rd1", tag), {32'b0, rd1_0}, m_rd(0, int'(ra1_0), we0, int'(wa0), {32'b0, wd0}));
    check($sformatf("%s u0.rd2", tag), {32'b0, rd2_0}, m_rd(0, int'(ra2_0), we0, int'(wa0), {32'b0, wd0}));
    check($sformatf("%s u0.busy1", tag), 64'(b1_0), 64'(m_busy(0, int'(ra1_0), we0, int'(wa0))));
    check($sformatf("%s u0.busy2", tag), 64'(b2_0), 64'(m_busy(0, int'(ra2_0), we0, int'(wa0))));
    check($sformatf("%s u0.iss_ready", tag), 64'(rdy0), 64'(m_ready(0, int'(ird0), we0, int'(wa0))));
    check($sformatf("%s u0.pend_cnt", tag), 64'(cnt0), 64'(m_count(0)));
    check($sformatf("%s u1.rd1", tag), rd1_1, m_rd(1, int'(ra1_1), we1, int'(wa1), wd1));
    check($sformatf("%s u1.rd2", tag), rd2_1, m_rd(1, int'(ra2_1), we1, int'(wa1), wd1));
    check($sformatf("%s u1.busy1", tag), 64'(b1_1), 64'(m_busy(1, int'(ra1_1), we1, int'(wa1))));
    check($sformatf("%s u1.busy2", tag), 64'(b2_1), 64'(m_busy(1, int'(ra2_1), we1, int'(wa1))));
    check($sformatf("%s u1.iss_ready", tag), 64'(rdy1), 64'(m_ready(1, int'(ird1), we1, int'(wa1))));
    check($sformatf("%s u1.pend_cnt", tag), 64'(cnt1), 64'(m_count(1)));
  endtask

  // Advance one clock: model takes the edge with the current inputs, then
  // the bench returns to the falling edge to drive the next cycle.
  task automatic clk_step();
    m_step(0, we0, int'(wa0), {32'b0, wd0}, iv0, int'(ird0));
    m_step(1, we1, int'(wa1), wd1, iv1, int'(ird1));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    we0 = 1'b0; iv0 = 1'b0; wa0 = '0; wd0 = '0; ra1_0 = '0; ra2_0 = '0; ird0 = '0;
    we1 = 1'b0; iv1 = 1'b0; wa1 = '0; wd1 = '0; ra1_1 = '0; ra2_1 = '0; ird1 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    m_clear();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  // ---------------- directed vector table for instance 0 -----------------
  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        iv;
    logic [4:0]  ird;
    logic [31:0] e_rd1;
    logic [31:0] e_rd2;
    logic        e_b1;
    logic        e_b2;
    logic        e_rdy;
    logic [5:0]  e_cnt;
  } vec_t;

  vec_t vecs [10];

  initial begin
    // write x0 / issue x0 are no-ops
    vecs[0] = '{1'b1, 5'd0, 32'hDEADBEEF, 5'd0, 5'd0, 1'b1, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 6'd0};
    vecs[1] = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 1'b1, 5'd5, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 6'd0};
    // x5 now pending
    vecs[2] = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd5, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 6'd1};
    // bypass write of x5 clears busy in the same cycle
    vecs[3] = '{1'b1, 5'd5, 32'h1234,     5'd5, 5'd5, 1'b0, 5'd5, 32'h1234, 32'h1234, 1'b0, 1'b0, 1'b1, 6'd1};
    vecs[4] = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd0, 1'b1, 5'd7, 32'h1234, 32'h0, 1'b0, 1'b0, 1'b1, 6'd0};
    // WAW on pending x7 stalls
    vecs[5] = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd5, 1'b1, 5'd7, 32'h0, 32'h1234, 1'b1, 1'b0, 1'b0, 6'd1};
    // writeback of x7 with re-issue: ready, new producer wins
    vecs[6] = '{1'b1, 5'd7, 32'hA5A50007, 5'd7, 5'd5, 1'b1, 5'd7, 32'hA5A50007, 32'h1234, 1'b0, 1'b0, 1'b1, 6'd1};
    // iss_ready does not depend on iss_valid
    vecs[7] = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd7, 1'b0, 5'd7, 32'hA5A50007, 32'hA5A50007, 1'b1, 1'b1, 1'b0, 6'd1};
    // write to non-pending x9 plus issue to a different register x3
    vecs[8] = '{1'b1, 5'd9, 32'h99,       5'd9, 5'd7, 1'b1, 5'd3, 32'h99, 32'hA5A50007, 1'b0, 1'b1, 1'b1, 6'd1};
    vecs[9] = '{1'b0, 5'd0, 32'h0,        5'd3, 5'd9, 1'b0, 5'd0, 32'h0, 32'h99, 1'b1, 1'b0, 1'b1, 6'd2};
  end

  // ---------------- main sequence -----------------------------------------
  initial begin
    logic [63:0] big;
    do_reset();

    // Reset state
    #1;
    check("reset rd1", {32'b0, rd1_0}, 64'h0);
    check("reset busy1", 64'(b1_0), 64'h0);
    check("reset iss_ready", 64'(rdy0), 64'h1);
    check("reset pend_cnt", 64'(cnt0), 64'h0);
    check("reset u1 pend_cnt", 64'(cnt1), 64'h0);
    @(negedge clk);

    // Table-driven directed vectors on instance 0
    for (int i = 0; i < 10; i++) begin
      we0 = vecs[i].we; wa0 = vecs[i].wa; wd0 = vecs[i].wd;
      ra1_0 = vecs[i].ra1; ra2_0 = vecs[i].ra2;
      iv0 = vecs[i].iv; ird0 = vecs[i].ird;
      #1;
      check($sformatf("vec%0d rd1", i), {32'b0, rd1_0}, {32'b0, vecs[i].e_rd1});
      check($sformatf("vec%0d rd2", i), {32'b0, rd2_0}, {32'b0, vecs[i].e_rd2});
      check($sformatf("vec%0d busy1", i), 64'(b1_0), 64'(vecs[i].e_b1));
      check($sformatf("vec%0d busy2", i), 64'(b2_0), 64'(vecs[i].e_b2));
      check($sformatf("vec%0d iss_ready", i), 64'(rdy0), 64'(vecs[i].e_rdy));
      check($sformatf("vec%0d pend_cnt", i), 64'(cnt0), 64'(vecs[i].e_cnt));
      clk_step();
    end
    idle_inputs();

    // Asynchronous reset mid-operation: x3 = 0x55 and pending
    do_reset();
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h55;
    clk_step();
    we0 = 1'b0; iv0 = 1'b1; ird0 = 5'd3;
    clk_step();
    iv0 = 1'b0; ird0 = 5'd3; ra1_0 = 5'd3;
    #1;
    check("pre-rst rd1", {32'b0, rd1_0}, 64'h55);
    check("pre-rst busy1", 64'(b1_0), 64'h1);
    check("pre-rst iss_ready", 64'(rdy0), 64'h0);
    #1 rst = 1'b1;
    #1;
    check("async rst rd1", {32'b0, rd1_0}, 64'h0);
    check("async rst busy1", 64'(b1_0), 64'h0);
    check("async rst pend_cnt", 64'(cnt0), 64'h0);
    check("async rst iss_ready", 64'(rdy0), 64'h1);
    m_clear();
    @(negedge clk);
    rst = 1'b0;

    // Fill: issue x1..x31, then write x31..x1
    for (int r = 1; r < 32; r++) begin
      iv0 = 1'b1; ird0 = 5'(r);
      #1 check($sformatf("fill issue x%0d ready", r), 64'(rdy0), 64'h1);
      clk_step();
    end
    iv0 = 1'b0; ird0 = '0;
    #1 check("fill pend_cnt", 64'(cnt0), 64'd31);
    for (int a = 0; a < 32; a++) begin
      ra1_0 = 5'(a);
      #1 check($sformatf("fill busy x%0d", a), 64'(b1_0), 64'(a != 0));
    end
    for (int r = 31; r > 0; r--) begin
      we0 = 1'b1; wa0 = 5'(r); wd0 = 32'(r) * 32'h01010101 ^ 32'hC3;
      clk_step();
    end
    we0 = 1'b0;
    #1 check("drain pend_cnt", 64'(cnt0), 64'd0);
    for (int a = 1; a < 32; a++) begin
      ra1_0 = 5'(a); ra2_0 = 5'(32 - a);
      #1;
      check($sformatf("readback x%0d", a), {32'b0, rd1_0}, {32'b0, 32'(a) * 32'h01010101 ^ 32'hC3});
      check($sformatf("readback2 x%0d", 32 - a), {32'b0, rd2_0}, {32'b0, 32'(32 - a) * 32'h01010101 ^ 32'hC3});
    end
    idle_inputs();

    // Parameter sweep instance: no zero reg, no bypass
    do_reset();
    big = 64'hFFFF_0000_FFFF_0000;
    we1 = 1'b1; wa1 = 4'd0; wd1 = big; ra1_1 = 4'd0;
    #1 check("u1 x0 same cycle", rd1_1, 64'h0);
    clk_step();
    we1 = 1'b0;
    #1 check("u1 x0 next cycle", rd1_1, big);
    for (int r = 0; r < 16; r++) begin
      iv1 = 1'b1; ird1 = 4'(r);
      clk_step();
    end
    iv1 = 1'b0;
    #1 check("u1 pend_cnt full", 64'(cnt1), 64'd16);
    check("u1 busy x0", 64'(b1_1), 64'h1);
    // same-register write + issue on a pending reg stalls without bypass
    we1 = 1'b1; wa1 = 4'd4; wd1 = 64'h0123_4567_89AB_CDEF; iv1 = 1'b1; ird1 = 4'd4; ra1_1 = 4'd4;
    #1;
    check("u1 stall ready", 64'(rdy1), 64'h0);
    check("u1 no bypass rd1", rd1_1, 64'h0);
    check("u1 no bypass busy1", 64'(b1_1), 64'h1);
    clk_step();
    we1 = 1'b0;
    #1;
    check("u1 retry ready", 64'(rdy1), 64'h1);
    check("u1 pend_cnt after wb", 64'(cnt1), 64'd15);
    check("u1 rd1 after wb", rd1_1, 64'h0123_4567_89AB_CDEF);
    clk_step();
    iv1 = 1'b0;
    #1 check("u1 pend_cnt reissue", 64'(cnt1), 64'd16);
    idle_inputs();

    // Randomized traffic on both instances against the model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      we0 = ($urandom_range(0, 9) < 4); wa0 = rnd_addr(); wd0 = $urandom;
      ra1_0 = rnd_addr(); ra2_0 = rnd_addr();
      iv0 = ($urandom_range(0, 1) == 1); ird0 = rnd_addr();
      we1 = ($urandom_range(0, 9) < 4); wa1 = 4'($urandom_range(0, 15));
      wd1 = {$urandom, $urandom};
      ra1_1 = 4'($urandom_range(0, 15)); ra2_1 = 4'($urandom_range(0, 15));
      iv1 = ($urandom_range(0, 1) == 1); ird1 = 4'($urandom_range(0, 15));
      #1 check_model($sformatf("rnd%0d", n));
      clk_step();
    end
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
